// File: rtl/mul_share_arbiter.sv
// Two-requester front end sharing one 8x8 unsigned multiplier.
// A round-robin arbiter feeds an operand stage (S1); the response stage (S2)
// holds the product with a valid/ready handshake toward the consumer.

// 8x8 unsigned multiplier: partial products reduced by carry-save rows
// following the Dadda height sequence 8 -> 6 -> 4 -> 3 -> 2, then one adder.
module dadda_multiplier (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] y_o
);

    logic [15:0] pp [8];
    logic [15:0] l1 [6];
    logic [15:0] l2 [4];
    logic [15:0] l3 [3];
    logic [15:0] sum_q2;
    logic [15:0] car_q2;

    // Every row sum stays below 2**16, so dropping the carry out of bit 15 is exact.
    function automatic logic [15:0] csa_sum(input logic [15:0] x, y, z);
        return x ^ y ^ z;
    endfunction

    function automatic logic [15:0] csa_car(input logic [15:0] x, y, z);
        return ((x & y) | (x & z) | (y & z)) << 1;
    endfunction

    // Partial-product generation and carry-save reduction tree.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            pp[i] = {8'd0, a_i & {8{b_i[i]}}} << i;
        end
        // 8 rows -> 6
        l1[0] = csa_sum(pp[0], pp[1], pp[2]);
        l1[1] = csa_car(pp[0], pp[1], pp[2]);
        l1[2] = csa_sum(pp[3], pp[4], pp[5]);
        l1[3] = csa_car(pp[3], pp[4], pp[5]);
        l1[4] = pp[6];
        l1[5] = pp[7];
        // 6 rows -> 4
        l2[0] = csa_sum(l1[0], l1[1], l1[2]);
        l2[1] = csa_car(l1[0], l1[1], l1[2]);
        l2[2] = csa_sum(l1[3], l1[4], l1[5]);
        l2[3] = csa_car(l1[3], l1[4], l1[5]);
        // 4 rows -> 3
        l3[0] = csa_sum(l2[0], l2[1], l2[2]);
        l3[1] = csa_car(l2[0], l2[1], l2[2]);
        l3[2] = l2[3];
        // 3 rows -> 2, then carry-propagate add
        sum_q2 = csa_sum(l3[0], l3[1], l3[2]);
        car_q2 = csa_car(l3[0], l3[1], l3[2]);
        y_o    = sum_q2 + car_q2;
    end

endmodule

module mul_share_arbiter #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    output logic        req1_ready,
    output logic        rsp_valid,
    output logic [15:0] rsp_y,
    output logic        rsp_id,
    input  logic        rsp_ready,
    output logic        busy,
    output logic [15:0] op_count
);

    logic        s1_v_q, s1_v_d;
    logic        s1_id_q, s1_id_d;
    logic [7:0]  s1_a_q, s1_a_d;
    logic [7:0]  s1_b_q, s1_b_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [15:0] rsp_y_q, rsp_y_d;
    logic        last_q, last_d;
    logic [15:0] op_count_q, op_count_d;

    logic        s2_adv;
    logic        s1_can;
    logic        gnt0;
    logic        gnt1;
    logic [15:0] mul_y;

    dadda_multiplier u_mul (
        .a_i (s1_a_q),
        .b_i (s1_b_q),
        .y_o (mul_y)
    );

    // Arbitration, handshakes and next-state for both pipeline stages.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        s1_v_d      = s1_v_q;
        s1_id_d     = s1_id_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_y_d     = rsp_y_q;
        last_d      = last_q;
        op_count_d  = op_count_q;

        s2_adv = s1_v_q & (~rsp_valid_q | rsp_ready);
        s1_can = ~s1_v_q | s2_adv;
        // On contention the requester that did not win last time goes first.
        gnt0 = rst_n & s1_can & req0_valid & (~req1_valid | last_q);
        gnt1 = rst_n & s1_can & req1_valid & (~req0_valid | ~last_q);

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
            op_count_d  = op_count_q + 16'd1;
        end
        if (s2_adv) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = s1_id_q;
            rsp_y_d     = mul_y;
            s1_v_d      = 1'b0;
        end
        if (gnt0 || gnt1) begin
            s1_v_d  = 1'b1;
            s1_id_d = gnt1;
            s1_a_d  = gnt1 ? req1_a : req0_a;
            s1_b_d  = gnt1 ? req1_b : req0_b;
            last_d  = gnt1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v_q      <= 1'b0;
            s1_id_q     <= 1'b0;
            s1_a_q      <= 8'd0;
            s1_b_q      <= 8'd0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_y_q     <= 16'd0;
            last_q      <= ~RR_INIT;
            op_count_q  <= 16'd0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            s1_v_q      <= s1_v_d;
            s1_id_q     <= s1_id_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_y_q     <= rsp_y_d;
            last_q      <= last_d;
            op_count_q  <= op_count_d;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_y      = rsp_y_q;
    assign rsp_id     = rsp_id_q;
    assign busy       = s1_v_q | rsp_valid_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Randomized and directed bench for mul_share_arbiter against a queue-based
// reference: operations in flight, grant order and products.
module tb_mul_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_ready, req1_ready;
    logic        rsp_valid, rsp_id, busy;
    logic [15:0] rsp_y, op_count;
    logic        rsp_ready = 1'b0;

    mul_share_arbiter #(.RR_INIT(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_y      (rsp_y),
        .rsp_id     (rsp_id),
        .rsp_ready  (rsp_ready),
        .busy       (busy),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          id;
        logic [15:0] y;
        int          acc;
    } item_t;

    item_t       q[$];
    bit          last_m;
    logic [15:0] cnt_m;
    int          cyc;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model reset state: empty pipeline, RR_INIT (0) wins first contention.
    task automatic model_reset();
        q.delete();
        last_m = 1'b1;
        cnt_m  = 16'd0;
    endtask

    // Called at a negedge with inputs already driven; checks, advances the model, moves to next negedge.
    task automatic step(output bit accepted);
        int n;
        bit can, g0, g1, vis;
        item_t it;
        #1;
        n   = q.size();
        // Two ops in flight fill both stages; only a draining response frees room.
        can = (n < 2) || rsp_ready;
        g0  = can && req0_valid && (!req1_valid || last_m);
        g1  = can && req1_valid && (!req0_valid || !last_m);
        // The oldest op is visible one full cycle after its operands were taken.
        vis = (n > 0) && (q[0].acc + 2 <= cyc);
        check("ready0", req0_ready, g0);
        check("ready1", req1_ready, g1);
        check("rsp_valid", rsp_valid, vis);
        check("busy", busy, n > 0);
        check("op_count", op_count, cnt_m);
        if (vis) begin
            check("rsp_y", rsp_y, q[0].y);
            check("rsp_id", rsp_id, q[0].id);
        end
        if (vis && rsp_ready) begin
            void'(q.pop_front());
            cnt_m = cnt_m + 16'd1;
        end
        if (g0 || g1) begin
            it.id  = g1;
            it.y   = g1 ? ({8'd0, req1_a} * {8'd0, req1_b}) : ({8'd0, req0_a} * {8'd0, req0_b});
            it.acc = cyc;
            q.push_back(it);
            last_m = g1;
        end
        accepted = g0 || g1;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Hold reset for one edge with requests pending; readies must stay low and all state clears.
    task automatic apply_reset();
        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready  = 1'b1;
        #1;
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_y", rsp_y, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_busy", busy, 0);
        check("rst_op_count", op_count, 0);
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        bit acc;
        logic [15:0] held_y;
        int k;
        int budget;
        logic [15:0] pair;

        cyc = 0;
        model_reset();
        @(negedge clk);
        apply_reset();

        // Single operation: 12 * 13 = 156.
        req0_valid = 1'b1; req0_a = 8'h0C; req0_b = 8'h0D; rsp_ready = 1'b1;
        step(acc);
        check("single_acc", acc, 1);
        req0_valid = 1'b0;
        step(acc);
        #1;
        check("single_valid", rsp_valid, 1);
        check("single_y", rsp_y, 16'h009C);
        check("single_id", rsp_id, 0);
        step(acc);
        #1;
        check("single_cnt", op_count, 1);

        // Contention from reset: grants alternate 0,1,0,1 with one response per cycle.
        apply_reset();
        req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'hFF;
        req1_valid = 1'b1; req1_a = 8'h00; req1_b = 8'h7F;
        rsp_ready  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("cont_gnt0", req0_ready, (i % 2) == 0);
            if (i >= 2) begin
                check("cont_tput", rsp_valid, 1);
                check("cont_y", rsp_y, (i % 2) == 0 ? 16'hFE01 : 16'h0000);
            end
            step(acc);
        end

        // Backpressure with req0 streaming.
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 3; i++) step(acc);
        rsp_ready = 1'b0;
        held_y = '0;
        for (int i = 0; i < 5; i++) begin
            req0_valid = 1'b1;
            req0_a = 8'($urandom); req0_b = 8'($urandom);
            #1;
            check("bp_ready0", req0_ready, i < 2);
            if (i == 2) held_y = rsp_y;
            if (i > 2) check("bp_hold", rsp_y, held_y);
            step(acc);
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req0_a = 8'($urandom); req0_b = 8'($urandom);
            step(acc);
        end
        req0_valid = 1'b0;
        for (int i = 0; i < 3; i++) step(acc);
        check("bp_drained", q.size(), 0);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            req0_valid = ($urandom % 4) != 0;
            req1_valid = ($urandom % 4) != 0;
            req0_a = 8'($urandom); req0_b = 8'($urandom);
            req1_a = 8'($urandom); req1_b = 8'($urandom);
            rsp_ready = ($urandom % 3) != 0;
            step(acc);
        end

        // Reset mid-operation: fill both stages under backpressure, then reset.
        rsp_ready = 1'b0; req1_valid = 1'b0; req0_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req0_a = 8'($urandom); req0_b = 8'($urandom);
            step(acc);
        end
        #1;
        check("mid_full", busy, 1);
        check("mid_rsp", rsp_valid, 1);
        apply_reset();
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("mid_no_stale", rsp_valid, 0);
            step(acc);
        end

        // Exhaustive a,b sweep alternating across both requesters; 65536 handshakes wrap op_count.
        k = 0;
        budget = 0;
        rsp_ready = 1'b1;
        while (k < 65536 && budget < 70000) begin
            pair = k[15:0];
            req0_valid = 1'b1; req1_valid = 1'b1;
            req0_a = pair[15:8]; req0_b = pair[7:0];
            req1_a = pair[15:8]; req1_b = pair[7:0];
            step(acc);
            if (acc) k++;
            budget++;
        end
        check("exh_budget", k, 65536);
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 3; i++) step(acc);
        check("wrap_count", op_count, 16'h0000);
        check("wrap_drained", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
